// File: rtl/icache_dm_if.sv
// CPU-fetch and backing-memory refill signals of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the CPU/memory side.
interface icache_dm_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_inst;
  logic              cpu_ready;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    output cpu_inst, cpu_ready, mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    input  cpu_inst, cpu_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line, read-only instruction cache with zero-latency hits.
// Optional ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt performance counter ports.
module icache_dm #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ICACHE_PERF_CNT_EN
  icache_dm_if.slave    bus,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`else
  icache_dm_if.slave    bus
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic              abort_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [INDEX_BITS-1:0] idx, ridx;
  logic [TAG_W-1:0]      tag_in, rtag;
  logic                  hit, start, done;
  logic                  unused_addr_bits;

  assign idx    = bus.cpu_addr[INDEX_BITS+1:2];
  assign tag_in = bus.cpu_addr[ADDR_W-1:INDEX_BITS+2];
  // Refill writes go to the latched address, so a redirected PC cannot disturb them.
  assign ridx   = mem_addr_q[INDEX_BITS+1:2];
  assign rtag   = mem_addr_q[ADDR_W-1:INDEX_BITS+2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        hit = bus.cpu_req && valid_q[idx] && (tag_mem[idx] == tag_in) && !bus.flush;
        if (bus.cpu_req && !hit && !bus.flush) begin
          start   = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (bus.mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_ready = hit;
  assign bus.cpu_inst  = hit ? data_mem[idx] : 32'd0;
  assign bus.mem_req   = (state_q == REFILL);
  assign bus.mem_addr  = mem_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      abort_q    <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (start)
        mem_addr_q <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
      // Flush beats a coincident ack: the line lands in the arrays but stays invalid.
      if (bus.flush)
        valid_q <= '0;
      else if (done && !abort_q)
        valid_q[ridx] <= 1'b1;
      abort_q <= (state_q == REFILL) && !done && (abort_q || bus.flush);
    end
  end

  always_ff @(posedge clk) begin
    if (done) begin
      tag_mem[ridx]  <= rtag;
      data_mem[ridx] <= bus.mem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (bus.flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)
        hit_cnt <= hit_cnt + 32'd1;
      if (start)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: per-cycle expected outputs are queued at drive time
// and compared on the falling edge.
module tb_icache_dm;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  icache_dm_if #(.ADDR_W(32)) bus ();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
  icache_dm #(.INDEX_BITS(6), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  icache_dm #(.INDEX_BITS(6), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rdy;
    logic [31:0] inst;
    logic        mreq;
    logic [31:0] maddr;
  } exp_t;

  exp_t exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == 32'h10) ? 32'h2008_0005 : {~a[15:0], a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq({e.tag, "/ready"}, {31'd0, bus.cpu_ready}, {31'd0, e.rdy});
      check_eq({e.tag, "/inst"},  bus.cpu_inst, e.inst);
      check_eq({e.tag, "/mem_req"}, {31'd0, bus.mem_req}, {31'd0, e.mreq});
      if (e.mreq)
        check_eq({e.tag, "/mem_addr"}, bus.mem_addr, e.maddr);
    end
  end

  task automatic step(input string tag, input logic req, input logic [31:0] addr,
                      input logic fl, input logic ack, input logic e_rdy,
                      input logic [31:0] e_inst, input logic e_mreq, input logic [31:0] e_maddr);
    exp_t e;
    bus.cpu_req   = req;
    bus.cpu_addr  = addr;
    bus.flush     = fl;
    bus.mem_ack   = ack;
    bus.mem_rdata = ack ? memword(e_maddr) : 32'hDEAD_BEEF;
    e.tag = tag; e.rdy = e_rdy; e.inst = e_inst; e.mreq = e_mreq; e.maddr = e_maddr;
    exp_q.push_back(e);
    if (fl) begin
      exp_hits = 0;
      exp_miss = 0;
    end else begin
      if (e_rdy) exp_hits++;
      if (req && !e_rdy && !e_mreq) exp_miss++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input string tag, input logic [31:0] addr);
    step(tag, 1'b1, addr, 1'b0, 1'b0, 1'b1, memword(addr), 1'b0, 32'd0);
  endtask

  task automatic fill(input string tag, input logic [31:0] addr, input int lat);
    step({tag, "_miss"}, 1'b1, addr, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < lat; i++)
      step({tag, "_wait"}, 1'b1, addr, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, addr);
    step({tag, "_ack"}, 1'b1, addr, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, addr);
  endtask

  task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_CNT_EN
    check_eq({tag, "/hit_cnt"}, hit_cnt, exp_hits);
    check_eq({tag, "/miss_cnt"}, miss_cnt, exp_miss);
`else
    check_eq({tag, "/q_idle"}, exp_q.size(), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10; bus.flush = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst/mem_req",  {31'd0, bus.mem_req},   32'd0);
    check_eq("rst/mem_addr", bus.mem_addr,           32'd0);
    check_eq("rst/ready",    {31'd0, bus.cpu_ready}, 32'd0);
    check_eq("rst/inst",     bus.cpu_inst,           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, then repeated hits
    fill("cold", 32'h10, 3);
    for (int i = 0; i < 6; i++) hit("hit10", 32'h10);
    check_counters("after_hits");

    // Stray ack while idle changes nothing
    step("ack_idle", 1'b0, 32'h10, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    hit("hit10_b", 32'h10);

    // Conflict eviction on index 4
    fill("evict110", 32'h110, 1);
    hit("hit110", 32'h110);
    fill("evict10", 32'h10, 2);
    hit("hit10_c", 32'h10);

    // Redirect during refill
    step("redir_miss", 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step("redir_wait", 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h20);
    step("redir_ack",  1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h20);
    fill("redir40", 32'h40, 1);
    hit("hit40", 32'h40);
    hit("hit20", 32'h20);
    check_counters("after_redir");

    // Flush while idle blocks the hit and invalidates everything
    step("flush_idle", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    fill("post_flush20", 32'h20, 0);
    hit("hit20_b", 32'h20);

    // Flush coincident with ack aborts the install
    step("abort_miss", 1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step("abort_wait", 1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h30);
    step("abort_ack",  1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h30);
    step("abort_idle", 1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_counters("after_flush");
    fill("refetch30", 32'h30, 1);
    hit("hit30", 32'h30);
    fill("refetch20", 32'h20, 0);
    fill("refetch10", 32'h10, 0);
    hit("hit10_d", 32'h10);

    // Flush earlier in the refill also leaves the line invalid
    step("abort2_miss", 1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step("abort2_fl",   1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h50);
    step("abort2_ack",  1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h50);
    fill("refetch50", 32'h50, 0);
    hit("hit50", 32'h50);
    check_counters("after_abort2");

    // Reset in the middle of a refill
    step("rstmid_miss", 1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step("rstmid_wait", 1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h60);
    rst = 1'b1;
    #1;
    check_eq("rstmid/mem_req", {31'd0, bus.mem_req},   32'd0);
    check_eq("rstmid/ready",   {31'd0, bus.cpu_ready}, 32'd0);
    exp_hits = 0;
    exp_miss = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step("late_ack", 1'b0, 32'h60, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    fill("post_rst50", 32'h50, 1);
    hit("hit50_b", 32'h50);
    check_counters("after_rst");

    @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, one-word-per-line, read-only instruction cache.
- Sits between the pipelined CPU's instruction port (inst_addr/inst_mem) and a multi-cycle backing instruction memory that uses a req/ack handshake.
- Hits return the instruction combinationally in the same cycle. A miss raises a stall, refills one line, then hits.
- When cpu_ready is 0, the CPU holds its PC and inserts a bubble.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines); tag = addr[31:INDEX_BITS+2].
- ADDR_W, 32, byte address width; addr[1:0] ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  fetch request valid this cycle.
- cpu_addr  in  ADDR_W  fetch byte address (the CPU's PC).
- cpu_inst  out  32  instruction word; 0 (NOP) when not a hit.
- cpu_ready  out  1  hit this cycle; CPU must stall when cpu_req=1 and cpu_ready=0.
- flush  in  1  invalidate all lines.
- mem_req  out  1  backing-memory read request, held until ack.
- mem_addr  out  ADDR_W  word-aligned refill address.
- mem_ack  in  1  one-cycle pulse: mem_rdata valid.
- mem_rdata  in  32  refill data.

Behaviour:
- Storage: valid[2^INDEX_BITS], tag array, data array. Index = cpu_addr[INDEX_BITS+1:2].
- Reset (async):
  - All valid bits cleared; state=IDLE.
  - Outputs: mem_req=0, mem_addr=0, cpu_ready=0, cpu_inst=0.
  - Tag and data arrays need no reset.
- hit = state==IDLE && cpu_req && valid[idx] && tag[idx]==cpu_addr tag field && !flush.
- cpu_ready = hit. cpu_inst = hit ? data[idx] : 0. Both are combinational, zero latency.
- IDLE -> REFILL:
  - Condition: cpu_req && !hit && !flush.
  - Latch mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00} and set mem_req=1 on the same edge.
- REFILL:
  - mem_req held at 1 and mem_addr held constant; cpu_ready=0.
  - On mem_ack: write data/tag at the latched index, set valid unless the abort flag is set, clear mem_req, go to IDLE.
  - The next cycle re-looks up the current cpu_addr.
- Miss penalty: 1 detect cycle + N backing-memory cycles + 1 re-lookup cycle. With same-cycle ack after the request edge, the hit occurs 2 cycles after the miss cycle.
- cpu_addr changes during REFILL (redirect):
  - The refill still completes to the latched address and installs the line.
  - No new request is issued until IDLE.
- flush:
  - In IDLE: all valid bits cleared on the edge; cpu_ready=0 that cycle.
  - In REFILL: valid bits cleared and abort flag set. The pending ack is consumed but the line is not marked valid. Abort flag clears on return to IDLE.
- Simultaneous flush and mem_ack: flush wins; the line is not installed.
- mem_ack in IDLE: ignored.
- cpu_req=0: no lookup side effects, no miss started; cpu_ready=0.
- Reset mid-REFILL: mem_req drops immediately (async). A late ack after reset is ignored.
- Tag compare covers the full tag field. Index aliasing evicts the previous line unconditionally.

Optional Feature:
- ICACHE_PERF_CNT_EN: when defined, adds two ports and two counters.
  - hit_cnt out 32: increments every cycle cpu_ready=1.
  - miss_cnt out 32: increments on each IDLE->REFILL transition.
  - Both are reset to 0 by rst, cleared by flush, and wrap at 2^32-1 -> 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: after reset, cpu_req=1, cpu_addr=0x00000010; memory acks 3 cycles after mem_req with 0x20080005.
  - Required: cpu_ready=0 and cpu_inst=0 until ack.
  - Required: mem_addr=0x10 stable throughout.
  - Required: next cycle cpu_ready=1, cpu_inst=0x20080005.
- Repeated hit: re-fetch 0x10 for 5 cycles -> cpu_ready=1 every cycle, mem_req never asserts; with the macro, hit_cnt increases by 5 and miss_cnt stays 1.
- Conflict eviction: fill 0x10, then fetch 0x110 (same index for INDEX_BITS=6).
  - Required: miss, refill, line replaced.
  - Required: fetching 0x10 again misses with mem_addr=0x10.
- Redirect during refill: miss on 0x20, switch cpu_addr to 0x40 before ack.
  - Required: ack installs 0x20.
  - Required: next cycle misses on 0x40 with a new mem_req, mem_addr=0x40.
- Flush abort: flush asserted the same cycle as mem_ack for 0x30.
  - Required: next fetch of 0x30 misses.
  - Required: all previously valid lines miss; with the macro, counters read 0.
- Reset mid-refill: assert rst while mem_req=1 -> mem_req=0 immediately; after release, an ack pulse causes no state change and previously cached addresses miss.
